// File: rtl/game_round_ctrl.sv
// Round sequencer for the two-player sequence-matching game.
// Replays an LFSR-generated target sequence that grows by one value per round,
// collects both players' commits under a per-step timeout, pulses Allow to the
// external player-sum adder and compares the returned 4-bit sum with the target.
module game_round_ctrl #(
  parameter int MAX_LEN     = 8,
  parameter int SHOW_CYCLES = 4,
  parameter int TIMEOUT     = 16,
  parameter int TW          = 8
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [3:0]    Seed,
  input  logic          P1_Valid,
  input  logic          P2_Valid,
  input  logic [3:0]    Sum,
  output logic          Allow,
  output logic          Show_En,
  output logic [3:0]    Show_Val,
  output logic [3:0]    Step,
  output logic [3:0]    Round,
  output logic [TW-1:0] Time_Left,
  output logic          Busy,
  output logic          Win,
  output logic          Lose
);

  localparam int SCW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHOW,
    S_INPUT,
    S_CHECK,
    S_WIN,
    S_LOSE
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      lfsr_reg, lfsr_next;
  logic [3:0]      seed_reg, seed_next;
  logic [3:0]      step_reg, step_next;
  logic [3:0]      round_reg, round_next;
  logic [SCW-1:0]  show_cnt_reg, show_cnt_next;
  logic [TW-1:0]   time_left_reg, time_left_next;
  logic            p1_flag_reg, p1_flag_next;
  logic            p2_flag_reg, p2_flag_next;
  logic            busy_reg, busy_next;
  logic            win_reg, win_next;
  logic            lose_reg, lose_next;

  // x^4 + x^3 + 1: maximal length 15, the all-zero state is never reached
  function automatic logic [3:0] lfsr_adv(input logic [3:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction

  // State and datapath registers; reset returns everything to the idle values
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg     <= S_IDLE;
      lfsr_reg      <= 4'd1;
      seed_reg      <= 4'd1;
      step_reg      <= 4'd0;
      round_reg     <= 4'd0;
      show_cnt_reg  <= '0;
      time_left_reg <= '0;
      p1_flag_reg   <= 1'b0;
      p2_flag_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      win_reg       <= 1'b0;
      lose_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lfsr_reg      <= lfsr_next;
      seed_reg      <= seed_next;
      step_reg      <= step_next;
      round_reg     <= round_next;
      show_cnt_reg  <= show_cnt_next;
      time_left_reg <= time_left_next;
      p1_flag_reg   <= p1_flag_next;
      p2_flag_reg   <= p2_flag_next;
      busy_reg      <= busy_next;
      win_reg       <= win_next;
      lose_reg      <= lose_next;
    end
  end

  // Next-state logic, datapath updates and the combinational display/Allow decode
  always_comb begin
    state_next     = state_reg;
    lfsr_next      = lfsr_reg;
    seed_next      = seed_reg;
    step_next      = step_reg;
    round_next     = round_reg;
    show_cnt_next  = show_cnt_reg;
    time_left_next = time_left_reg;
    p1_flag_next   = p1_flag_reg;
    p2_flag_next   = p2_flag_reg;

    if (Start) begin
      // Start restarts from any state; a zero seed would lock the LFSR
      seed_next      = (Seed == 4'd0) ? 4'd1 : Seed;
      lfsr_next      = seed_next;
      step_next      = 4'd0;
      round_next     = 4'd0;
      show_cnt_next  = '0;
      time_left_next = '0;
      p1_flag_next   = 1'b0;
      p2_flag_next   = 1'b0;
      state_next     = S_SHOW;
    end else begin
      case (state_reg)
        S_SHOW: begin
          if (show_cnt_reg == SCW'(SHOW_CYCLES - 1)) begin
            show_cnt_next = '0;
            if (step_reg == round_reg) begin
              // Whole sequence shown: replay it from the seed for the players
              lfsr_next      = seed_reg;
              step_next      = 4'd0;
              time_left_next = TW'(TIMEOUT);
              state_next     = S_INPUT;
            end else begin
              lfsr_next = lfsr_adv(lfsr_reg);
              step_next = step_reg + 4'd1;
            end
          end else begin
            show_cnt_next = show_cnt_reg + SCW'(1);
          end
        end
        S_INPUT: begin
          p1_flag_next = p1_flag_reg | P1_Valid;
          p2_flag_next = p2_flag_reg | P2_Valid;
          // Completion wins over expiry when both happen on the same edge
          if (p1_flag_next && p2_flag_next) begin
            time_left_next = '0;
            state_next     = S_CHECK;
          end else if (time_left_reg == TW'(1)) begin
            time_left_next = '0;
            state_next     = S_LOSE;
          end else begin
            time_left_next = time_left_reg - TW'(1);
          end
        end
        S_CHECK: begin
          p1_flag_next = 1'b0;
          p2_flag_next = 1'b0;
          if (Sum == lfsr_reg) begin
            if (step_reg < round_reg) begin
              step_next      = step_reg + 4'd1;
              lfsr_next      = lfsr_adv(lfsr_reg);
              time_left_next = TW'(TIMEOUT);
              state_next     = S_INPUT;
            end else if (round_reg == 4'(MAX_LEN - 1)) begin
              state_next = S_WIN;
            end else begin
              round_next    = round_reg + 4'd1;
              step_next     = 4'd0;
              lfsr_next     = seed_reg;
              show_cnt_next = '0;
              state_next    = S_SHOW;
            end
          end else begin
            state_next = S_LOSE;
          end
        end
        default: begin
          // IDLE, WIN and LOSE hold until Start
        end
      endcase
    end

    busy_next = (state_next == S_SHOW) || (state_next == S_INPUT) || (state_next == S_CHECK);
    win_next  = (state_next == S_WIN);
    lose_next = (state_next == S_LOSE);

    Allow    = (state_reg == S_CHECK);
    Show_En  = (state_reg == S_SHOW);
    Show_Val = (state_reg == S_SHOW) ? lfsr_reg : 4'd0;
  end

  assign Step      = step_reg;
  assign Round     = round_reg;
  assign Time_Left = time_left_reg;
  assign Busy      = busy_reg;
  assign Win       = win_reg;
  assign Lose      = lose_reg;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: plays whole games with randomized
// player timing and values against a round/step model of the game rules.
module tb_game_round_ctrl;
  localparam int MAX_LEN     = 4;
  localparam int SHOW_CYCLES = 4;
  localparam int TIMEOUT     = 16;
  localparam int TW          = 8;
  localparam int NEVER       = 99;

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Start = 1'b0;
  logic [3:0]    Seed = 4'd0;
  logic          P1_Valid = 1'b0;
  logic          P2_Valid = 1'b0;
  logic [3:0]    Sum;
  logic          Allow, Show_En, Busy, Win, Lose;
  logic [3:0]    Show_Val, Step, Round;
  logic [TW-1:0] Time_Left;

  logic [3:0] p1_val = 4'd0;
  logic [3:0] p2_val = 4'd0;
  int total = 0;
  int bad = 0;
  int allow_cnt = 0;

  game_round_ctrl #(
    .MAX_LEN(MAX_LEN), .SHOW_CYCLES(SHOW_CYCLES), .TIMEOUT(TIMEOUT), .TW(TW)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Seed(Seed),
    .P1_Valid(P1_Valid), .P2_Valid(P2_Valid), .Sum(Sum), .Allow(Allow),
    .Show_En(Show_En), .Show_Val(Show_Val), .Step(Step), .Round(Round),
    .Time_Left(Time_Left), .Busy(Busy), .Win(Win), .Lose(Lose)
  );

  always #5 Clock = ~Clock;

  // Player-sum adder model: 4-bit wraparound sum, forced to 0 while Allow is low
  assign Sum = Allow ? 4'(p1_val + p2_val) : 4'd0;

  always @(posedge Clock) if (Allow === 1'b1) allow_cnt <= allow_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Target value idx of the sequence started from seed (x^4+x^3+1 shift register)
  function automatic logic [3:0] target(input logic [3:0] seed, input int idx);
    logic [3:0] q;
    q = (seed == 4'd0) ? 4'd1 : seed;
    for (int i = 0; i < idx; i++) q = {q[2:0], q[3] ^ q[2]};
    return q;
  endfunction

  // Plays one game from a Start pulse; the step (fr,fs) uses the given delays and
  // values, every other step gets random delays and a correct random split.
  task automatic play_game(input logic [3:0] seed, input int fr, input int fs,
                           input int sd1, input int sd2,
                           input logic [3:0] sa, input logic [3:0] sb);
    bit done, lost;
    int lr, ls, exp_allow, a0, d1, d2, c;
    logic [3:0] a, b, tgt;
    done = 0; lost = 0; lr = 0; ls = 0; exp_allow = 0;
    P1_Valid = 0; P2_Valid = 0;
    @(negedge Clock);
    Start = 1; Seed = seed;
    @(negedge Clock);
    Start = 0;
    a0 = allow_cnt;
    for (int r = 0; r < MAX_LEN && !done; r++) begin
      for (int v = 0; v <= r; v++) begin
        for (int k = 0; k < SHOW_CYCLES; k++) begin
          total++;
          if (Show_En !== 1'b1 || Show_Val !== target(seed, v) || Step !== 4'(v) ||
              Round !== 4'(r) || Busy !== 1'b1 || Allow !== 1'b0 || Time_Left !== '0) begin
            bad++;
            $display("FAIL show seed=%0d r=%0d v=%0d k=%0d: en=%b val=%0d step=%0d round=%0d busy=%b allow=%b tl=%0d, want en=1 val=%0d step=%0d round=%0d busy=1 allow=0 tl=0",
                     seed, r, v, k, Show_En, Show_Val, Step, Round, Busy, Allow, Time_Left, target(seed, v), v, r);
          end
          P1_Valid = 1'($urandom % 2);
          P2_Valid = 1'($urandom % 2);
          @(negedge Clock);
        end
      end
      P1_Valid = 0; P2_Valid = 0;
      for (int s = 0; s <= r && !done; s++) begin
        tgt = target(seed, s);
        if (r == fr && s == fs) begin
          d1 = sd1; d2 = sd2; a = sa; b = sb;
        end else begin
          d1 = $urandom_range(0, 5); d2 = $urandom_range(0, 5);
          a = 4'($urandom); b = tgt - a;
        end
        c = (d1 > d2) ? d1 : d2;
        for (int t = 0; t < TIMEOUT && t <= c; t++) begin
          total++;
          if (Time_Left !== TW'(TIMEOUT - t) || Show_En !== 1'b0 || Busy !== 1'b1 ||
              Step !== 4'(s) || Round !== 4'(r) || Allow !== 1'b0) begin
            bad++;
            $display("FAIL input r=%0d s=%0d t=%0d: tl=%0d en=%b busy=%b step=%0d round=%0d allow=%b, want tl=%0d en=0 busy=1 step=%0d round=%0d allow=0",
                     r, s, t, Time_Left, Show_En, Busy, Step, Round, Allow, TIMEOUT - t, s, r);
          end
          P1_Valid = (t == d1) || (t > d1 && ($urandom % 3) == 0);
          P2_Valid = (t == d2) || (t > d2 && ($urandom % 3) == 0);
          if (t == d1) p1_val = a;
          if (t == d2) p2_val = b;
          @(negedge Clock);
        end
        P1_Valid = 0; P2_Valid = 0;
        if (c >= TIMEOUT) begin
          lost = 1; done = 1; lr = r; ls = s;
        end else begin
          exp_allow++;
          total++;
          if (Allow !== 1'b1 || Time_Left !== '0 || Busy !== 1'b1 || Show_En !== 1'b0) begin
            bad++;
            $display("FAIL check r=%0d s=%0d: allow=%b tl=%0d busy=%b en=%b, want allow=1 tl=0 busy=1 en=0",
                     r, s, Allow, Time_Left, Busy, Show_En);
          end
          P1_Valid = 1'($urandom % 2);
          P2_Valid = 1'($urandom % 2);
          @(negedge Clock);
          P1_Valid = 0; P2_Valid = 0;
          if (4'(a + b) != tgt) begin
            lost = 1; done = 1; lr = r; ls = s;
          end else if (s == r && r == MAX_LEN - 1) begin
            done = 1;
          end
        end
      end
    end
    total++;
    if (lost) begin
      if (Lose !== 1'b1 || Win !== 1'b0 || Busy !== 1'b0 || Step !== 4'(ls) ||
          Round !== 4'(lr) || Time_Left !== '0 || Show_En !== 1'b0) begin
        bad++;
        $display("FAIL lose_end: lose=%b win=%b busy=%b step=%0d round=%0d tl=%0d en=%b, want lose=1 win=0 busy=0 step=%0d round=%0d tl=0 en=0",
                 Lose, Win, Busy, Step, Round, Time_Left, Show_En, ls, lr);
      end
    end else begin
      if (Win !== 1'b1 || Lose !== 1'b0 || Busy !== 1'b0 || Step !== 4'(MAX_LEN - 1) ||
          Round !== 4'(MAX_LEN - 1) || Time_Left !== '0) begin
        bad++;
        $display("FAIL win_end: win=%b lose=%b busy=%b step=%0d round=%0d tl=%0d, want win=1 lose=0 busy=0 step=%0d round=%0d tl=0",
                 Win, Lose, Busy, Step, Round, Time_Left, MAX_LEN - 1, MAX_LEN - 1);
      end
    end
    total++;
    if (allow_cnt - a0 != exp_allow) begin
      bad++;
      $display("FAIL allow_count: got %0d, want %0d", allow_cnt - a0, exp_allow);
    end
    repeat (3) begin
      P1_Valid = 1'($urandom % 2);
      P2_Valid = 1'($urandom % 2);
      @(negedge Clock);
    end
    P1_Valid = 0; P2_Valid = 0;
    total++;
    if (Win !== !lost || Lose !== lost || Allow !== 1'b0 ||
        Step !== (lost ? 4'(ls) : 4'(MAX_LEN - 1)) || Round !== (lost ? 4'(lr) : 4'(MAX_LEN - 1))) begin
      bad++;
      $display("FAIL end_hold: win=%b lose=%b allow=%b step=%0d round=%0d, want win=%b lose=%b allow=0 held step/round",
               Win, Lose, Allow, Step, Round, !lost, lost);
    end
    $display("game seed=%0d result=%s allow_pulses=%0d", seed, lost ? "lose" : "win", allow_cnt - a0);
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if (Allow !== 1'b0 || Show_En !== 1'b0 || Show_Val !== 4'd0 || Step !== 4'd0 ||
        Round !== 4'd0 || Time_Left !== '0 || Busy !== 1'b0 || Win !== 1'b0 || Lose !== 1'b0) begin
      bad++;
      $display("FAIL %s: allow=%b en=%b val=%0d step=%0d round=%0d tl=%0d busy=%b win=%b lose=%b, want all 0",
               tag, Allow, Show_En, Show_Val, Step, Round, Time_Left, Busy, Win, Lose);
    end
  endtask

  task automatic test_reset();
    Reset_n = 0;
    repeat (3) @(negedge Clock);
    check_all_zero("reset_held");
    Reset_n = 1;
    repeat (2) begin
      P1_Valid = 1; P2_Valid = 1;
      @(negedge Clock);
    end
    P1_Valid = 0; P2_Valid = 0;
    check_all_zero("idle_after_reset");
    $display("test_reset done");
  endtask

  task automatic test_full_game();
    int a0;
    a0 = allow_cnt;
    play_game(4'd1, NEVER, NEVER, 0, 0, 4'd0, 4'd0);
    total++;
    if (allow_cnt - a0 != 10) begin
      bad++;
      $display("FAIL full_game_allow_total: got %0d, want 10", allow_cnt - a0);
    end
  endtask

  task automatic test_mismatch();
    play_game(4'd1, 1, 1, 1, 3, 4'd1, 4'd2);
  endtask

  task automatic test_timeout();
    play_game(4'($urandom_range(1, 15)), 0, 0, $urandom_range(0, 5), NEVER, 4'd0, 4'd0);
    play_game(4'd1, 2, 1, NEVER, 3, 4'd0, 4'd0);
  endtask

  task automatic test_last_cycle();
    logic [3:0] sd, a;
    sd = 4'($urandom_range(1, 15));
    a = 4'($urandom);
    play_game(sd, 1, 0, 2, TIMEOUT - 1, a, target(sd, 0) - a);
  endtask

  task automatic test_seed_zero();
    play_game(4'd0, 1, 1, 0, 0, 4'd9, 4'd9);
  endtask

  task automatic test_restart();
    @(negedge Clock);
    Start = 1; Seed = 4'd3;
    @(negedge Clock);
    Start = 0;
    repeat (SHOW_CYCLES) @(negedge Clock);
    P1_Valid = 1;
    @(negedge Clock);
    P1_Valid = 0;
    repeat (2) @(negedge Clock);
    play_game(4'd5, NEVER, NEVER, 0, 0, 4'd0, 4'd0);
  endtask

  task automatic test_reset_mid_show();
    @(negedge Clock);
    Start = 1; Seed = 4'd7;
    @(negedge Clock);
    Start = 0;
    repeat (2) @(negedge Clock);
    Reset_n = 0;
    #1;
    check_all_zero("reset_mid_show");
    @(negedge Clock);
    Reset_n = 1;
    repeat (2) @(negedge Clock);
    check_all_zero("idle_after_mid_reset");
    $display("test_reset_mid_show done");
  endtask

  task automatic test_back_to_back();
    logic [3:0] sd, a, b, tg;
    int fr, fs, kind, d1, d2;
    for (int g = 0; g < 6; g++) begin
      sd = 4'($urandom);
      fr = $urandom_range(0, MAX_LEN - 1);
      fs = $urandom_range(0, fr);
      kind = $urandom_range(0, 2);
      tg = target(sd, fs);
      a = 4'($urandom);
      d1 = $urandom_range(0, TIMEOUT - 1);
      d2 = $urandom_range(0, TIMEOUT - 1);
      if (kind == 0) b = tg - a;
      else b = tg - a + 4'($urandom_range(1, 15));
      if (kind == 2) begin
        if ($urandom % 2 == 0) d1 = NEVER;
        else d2 = NEVER;
      end
      play_game(sd, fr, fs, d1, d2, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_full_game();
    test_mismatch();
    test_timeout();
    test_last_cycle();
    test_seed_zero();
    test_restart();
    test_reset_mid_show();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
